tmds_timing_gen: RTL and testbench

Transmit-side video timing and HDMI period generator for the TMDS output path. It free-runs a 1280x720p60 raster on the pixel clock and produces hsync, vsync, de and pixel coordinates for the dvi_encoder inputs. It also produces the HDMI period schedule: video preamble and guard band before each active line, plus an optional per-line data-island window. The schedule is granted to an audio/packet source through a request/acknowledge handshake.

---
 rtl/tmds_pkg.sv | 31 +++
 rtl/tmds_period_fsm.sv | 72 +++++++
 rtl/tmds_timing_gen.sv | 105 ++++++++++
 tb/tb_tmds_timing_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - period encodings, 720p60 defaults and raster total derivation
package tmds_pkg;

   localparam logic [2:0] PER_CTRL     = 3'd0;
   localparam logic [2:0] PER_VID_PRE  = 3'd1;
   localparam logic [2:0] PER_VID_GB   = 3'd2;
   localparam logic [2:0] PER_VIDEO    = 3'd3;
   localparam logic [2:0] PER_ISL_PRE  = 3'd4;
   localparam logic [2:0] PER_ISL_GB   = 3'd5;
   localparam logic [2:0] PER_ISL_DATA = 3'd6;

   localparam int DEF_H_ACTIVE  = 1280;
   localparam int DEF_H_FP      = 110;
   localparam int DEF_H_SYNC    = 40;
   localparam int DEF_H_BP      = 220;
   localparam int DEF_V_ACTIVE  = 720;
   localparam int DEF_V_FP      = 5;
   localparam int DEF_V_SYNC    = 5;
   localparam int DEF_V_BP      = 20;
   localparam int DEF_SYNC_POL  = 1;
   localparam int DEF_ISL_START = 1438;
   localparam int DEF_ISL_LEN   = 32;

   function automatic int line_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   localparam int DEF_H_TOTAL = line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int DEF_V_TOTAL = line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/tmds_period_fsm.sv
// rtl/tmds_period_fsm.sv - per-line HDMI period schedule with island grant handshake
module tmds_period_fsm
   import tmds_pkg::*;
#(
   parameter int H_TOTAL   = DEF_H_TOTAL,
   parameter int ISL_START = DEF_ISL_START,
   parameter int ISL_LEN   = DEF_ISL_LEN
) (
   input  logic        pclk,
   input  logic        rstbtn_n,
   input  logic [10:0] hpos,
   input  logic        pix_active,
   input  logic        vpos_next_active,
   input  logic        island_req,
   output logic [2:0]  period,
   output logic        island_ack
);

   localparam logic [10:0] VP_START   = 11'(H_TOTAL - 10);
   localparam logic [10:0] VG_START   = 11'(H_TOTAL - 2);
   localparam logic [10:0] ISL_SAMPLE = 11'(ISL_START - 1);
   localparam logic [10:0] ISL_PRE_S  = 11'(ISL_START);
   localparam logic [10:0] ISL_GB1_S  = 11'(ISL_START + 8);
   localparam logic [10:0] ISL_DATA_S = 11'(ISL_START + 10);
   localparam logic [10:0] ISL_GB2_S  = 11'(ISL_START + 10 + ISL_LEN);
   localparam logic [10:0] ISL_END    = 11'(ISL_START + 12 + ISL_LEN);

   typedef enum logic {ISL_IDLE, ISL_GRANTED} isl_state_t;

   isl_state_t state, state_next;
   logic [2:0] period_next;
   logic       ack_next;

   always_ff @(posedge pclk) begin
      if (!rstbtn_n) begin
         state      <= ISL_IDLE;
         period     <= PER_CTRL;
         island_ack <= 1'b0;
      end else begin
         state      <= state_next;
         period     <= period_next;
         island_ack <= ack_next;
      end
   end

   // The grant is re-decided once per line; outside the island window it is inert.
   always_comb begin
      state_next  = state;
      period_next = PER_CTRL;
      ack_next    = 1'b0;
      if (hpos == ISL_SAMPLE) begin
         state_next = island_req ? ISL_GRANTED : ISL_IDLE;
      end
      if (pix_active) begin
         period_next = PER_VIDEO;
      end else if (vpos_next_active && hpos >= VG_START) begin
         period_next = PER_VID_GB;
      end else if (vpos_next_active && hpos >= VP_START) begin
         period_next = PER_VID_PRE;
      end else if (state == ISL_GRANTED && hpos >= ISL_PRE_S && hpos < ISL_END) begin
         if (hpos < ISL_GB1_S) begin
            period_next = PER_ISL_PRE;
         end else if (hpos < ISL_DATA_S || hpos >= ISL_GB2_S) begin
            period_next = PER_ISL_GB;
         end else begin
            period_next = PER_ISL_DATA;
            ack_next    = (hpos == ISL_DATA_S);
         end
      end
   end

endmodule

// File: rtl/tmds_timing_gen.sv
// rtl/tmds_timing_gen.sv - free-running raster counters, sync decode and period schedule
module tmds_timing_gen
   import tmds_pkg::*;
#(
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP,
   parameter int SYNC_POL  = DEF_SYNC_POL,
   parameter int ISL_START = DEF_ISL_START,
   parameter int ISL_LEN   = DEF_ISL_LEN
) (
   input  logic        pclk,
   input  logic        rstbtn_n,
   output logic        hsync,
   output logic        vsync,
   output logic        video_en,
   output logic [10:0] video_hcnt,
   output logic [10:0] video_vcnt,
   output logic [2:0]  period,
   output logic        frame_start,
   input  logic        island_req,
   output logic        island_ack
);

   localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT_W    = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT_W    = 11'(V_ACTIVE);
   localparam logic [10:0] V_ACT_LAST = 11'(V_ACTIVE - 1);
   localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic        SYNC_ON    = (SYNC_POL != 0);

   generate
      if (ISL_START + 12 + ISL_LEN > H_TOTAL - 10) begin : g_isl_overlap
         $error("tmds_timing_gen: data-island window runs into the video preamble");
      end
      if (ISL_LEN <= 0 || (ISL_LEN % 32) != 0) begin : g_isl_len
         $error("tmds_timing_gen: ISL_LEN must be a positive multiple of 32");
      end
   endgenerate

   logic [10:0] hpos, vpos;
   logic        pix_active, next_active;

   always_ff @(posedge pclk) begin
      if (!rstbtn_n) begin
         hpos <= '0;
         vpos <= '0;
      end else if (hpos == H_LAST) begin
         hpos <= '0;
         vpos <= (vpos == V_LAST) ? 11'd0 : vpos + 11'd1;
      end else begin
         hpos <= hpos + 11'd1;
      end
   end

   assign pix_active  = (hpos < H_ACT_W) && (vpos < V_ACT_W);
   // The last blanking line precedes line 0, so it too carries a video preamble.
   assign next_active = (vpos == V_LAST) || (vpos < V_ACT_LAST);

   always_ff @(posedge pclk) begin
      if (!rstbtn_n) begin
         hsync       <= ~SYNC_ON;
         vsync       <= ~SYNC_ON;
         video_en    <= 1'b0;
         video_hcnt  <= '0;
         video_vcnt  <= '0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= (hpos >= HS_START && hpos < HS_END) ? SYNC_ON : ~SYNC_ON;
         vsync       <= (vpos >= VS_START && vpos < VS_END) ? SYNC_ON : ~SYNC_ON;
         video_en    <= pix_active;
         video_hcnt  <= pix_active ? hpos : 11'd0;
         video_vcnt  <= pix_active ? vpos : 11'd0;
         frame_start <= (hpos == 11'd0) && (vpos == 11'd0);
      end
   end

   tmds_period_fsm #(
      .H_TOTAL   (H_TOTAL),
      .ISL_START (ISL_START),
      .ISL_LEN   (ISL_LEN)
   ) u_period_fsm (
      .pclk             (pclk),
      .rstbtn_n         (rstbtn_n),
      .hpos             (hpos),
      .pix_active       (pix_active),
      .vpos_next_active (next_active),
      .island_req       (island_req),
      .period           (period),
      .island_ack       (island_ack)
   );

endmodule

// File: tb/tb_tmds_timing_gen.sv
// tb/tb_tmds_timing_gen.sv - randomized island requests against a raster model, two geometries
module tb_tmds_timing_gen;

   typedef struct {
      int ha, hfp, hs, hbp, va, vfp, vs, vbp, pol, isl, ilen;
   } cfg_t;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        en;
      logic [10:0] hc;
      logic [10:0] vc;
      logic [2:0]  per;
      logic        fs;
      logic        ack;
   } out_t;

   localparam int L10 = 10 * 1650 + 1438;
   localparam int L11 = 11 * 1650 + 1438;
   localparam int L12 = 12 * 1650 + 1438;
   localparam int RUN_CYCLES = L12 + 60;

   logic pclk = 1'b0;
   logic rst_d = 1'b0;
   logic rst_s = 1'b0;
   logic island_req = 1'b0;

   logic        d_hsync, d_vsync, d_video_en, d_frame_start, d_island_ack;
   logic [10:0] d_hcnt, d_vcnt;
   logic [2:0]  d_period;
   logic        s_hsync, s_vsync, s_video_en, s_frame_start, s_island_ack;
   logic [10:0] s_hcnt, s_vcnt;
   logic [2:0]  s_period;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   bit valid = 1'b0;

   int   mh [2];
   int   mv [2];
   int   frames [2];
   bit   grant [2];
   out_t exp_o [2];

   always #5 pclk = ~pclk;

   tmds_timing_gen u_dut_d (
      .pclk(pclk), .rstbtn_n(rst_d), .hsync(d_hsync), .vsync(d_vsync),
      .video_en(d_video_en), .video_hcnt(d_hcnt), .video_vcnt(d_vcnt),
      .period(d_period), .frame_start(d_frame_start),
      .island_req(island_req), .island_ack(d_island_ack)
   );

   tmds_timing_gen #(
      .H_ACTIVE(32), .H_FP(8), .H_SYNC(8), .H_BP(48),
      .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(5),
      .SYNC_POL(0), .ISL_START(34), .ISL_LEN(32)
   ) u_dut_s (
      .pclk(pclk), .rstbtn_n(rst_s), .hsync(s_hsync), .vsync(s_vsync),
      .video_en(s_video_en), .video_hcnt(s_hcnt), .video_vcnt(s_vcnt),
      .period(s_period), .frame_start(s_frame_start),
      .island_req(island_req), .island_ack(s_island_ack)
   );

   function automatic cfg_t cfg_of(input int k);
      cfg_t c;
      if (k == 0) c = '{1280, 110, 40, 220, 720, 5, 5, 20, 1, 1438, 32};
      else        c = '{32, 8, 8, 48, 10, 2, 3, 5, 0, 34, 32};
      return c;
   endfunction

   function automatic out_t reset_out(input cfg_t c);
      out_t r;
      r     = '0;
      r.hs  = (c.pol == 0);
      r.vs  = (c.pol == 0);
      return r;
   endfunction

   // What the raster looks like at pixel (h, v), from the timing rules alone.
   function automatic out_t model(input cfg_t c, input int h, input int v, input bit g);
      out_t r;
      int ht, vt, o;
      bit act, nxt, pol;
      ht  = c.ha + c.hfp + c.hs + c.hbp;
      vt  = c.va + c.vfp + c.vs + c.vbp;
      pol = (c.pol != 0);
      act = (h < c.ha) && (v < c.va);
      nxt = ((v + 1) % vt) < c.va;
      o   = h - c.isl;
      r     = '0;
      r.hs  = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) ? pol : !pol;
      r.vs  = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) ? pol : !pol;
      r.en  = act;
      r.hc  = act ? 11'(h) : 11'd0;
      r.vc  = act ? 11'(v) : 11'd0;
      r.fs  = (h == 0) && (v == 0);
      if (act) r.per = 3'd3;
      else if (nxt && h >= ht - 10 && h < ht - 2) r.per = 3'd1;
      else if (nxt && h >= ht - 2) r.per = 3'd2;
      else if (g && o >= 0 && o < c.ilen + 12) begin
         if (o < 8) r.per = 3'd4;
         else if (o < 10) r.per = 3'd5;
         else if (o < 10 + c.ilen) begin
            r.per = 3'd6;
            r.ack = (o == 10);
         end else r.per = 3'd5;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, want);
      end
   endtask

   always @(posedge pclk) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         cfg_t c;
         bit   rst_n;
         c     = cfg_of(k);
         rst_n = (k == 0) ? rst_d : rst_s;
         if (!rst_n) begin
            mh[k]    = 0;
            mv[k]    = 0;
            grant[k] = 1'b0;
            exp_o[k] = reset_out(c);
         end else begin
            exp_o[k] = model(c, mh[k], mv[k], grant[k]);
            if (mh[k] == c.isl - 1) grant[k] = island_req;
            mh[k]++;
            if (mh[k] == c.ha + c.hfp + c.hs + c.hbp) begin
               mh[k] = 0;
               mv[k]++;
               if (mv[k] == c.va + c.vfp + c.vs + c.vbp) begin
                  mv[k] = 0;
                  frames[k]++;
               end
            end
         end
      end
      valid = 1'b1;
   end

   always @(negedge pclk) begin
      if (valid) begin
         check("default_outputs",
               32'({d_hsync, d_vsync, d_video_en, d_hcnt, d_vcnt, d_period, d_frame_start, d_island_ack}),
               32'(exp_o[0]));
         check("small_outputs",
               32'({s_hsync, s_vsync, s_video_en, s_hcnt, s_vcnt, s_period, s_frame_start, s_island_ack}),
               32'(exp_o[1]));
      end
   end

   // Random request level, pinned at the sample points of the lines under scrutiny.
   always @(negedge pclk) begin
      logic r;
      r = 1'($urandom_range(0, 1));
      if (mh[1] == 33 && mv[1] == 7) r = 1'b1;
      if (mh[0] == 1437) begin
         if (mv[0] == 10) r = 1'b1;
         else if (mv[0] == 11 || mv[0] == 12) r = 1'b0;
      end
      island_req = r;
   end

   initial begin
      int en0, hs0, hs0_first, d_fs_cnt, d_vs_cnt, ack10, quiet;
      int s_vs, s_vs_first, s_pre, s_gb, rst_phase, ack_after, ack_win;
      en0 = 1; hs0 = 0; hs0_first = -1; d_fs_cnt = 0; d_vs_cnt = 0; ack10 = 0; quiet = 0;
      s_vs = 0; s_vs_first = -1; s_pre = 0; s_gb = 0; rst_phase = 0; ack_after = 0; ack_win = 0;

      repeat (3) @(negedge pclk);
      check("reset_video_en", 32'(d_video_en), 32'd0);
      check("reset_period", 32'(d_period), 32'd0);
      check("reset_hsync_pos", 32'(d_hsync), 32'd0);
      check("reset_hsync_neg", 32'(s_hsync), 32'd1);
      check("reset_vsync_neg", 32'(s_vsync), 32'd1);
      rst_d = 1'b1;
      rst_s = 1'b1;

      @(negedge pclk);
      check("first_video_en", 32'(d_video_en), 32'd1);
      check("first_hcnt", 32'(d_hcnt), 32'd0);
      check("first_vcnt", 32'(d_vcnt), 32'd0);
      check("first_frame_start", 32'(d_frame_start), 32'd1);
      check("first_period", 32'(d_period), 32'd3);
      check("small_first_frame_start", 32'(s_frame_start), 32'd1);

      for (int i = 1; i < RUN_CYCLES; i++) begin
         @(negedge pclk);
         if (i < 1650) begin
            if (d_video_en) en0++;
            if (d_hsync) begin
               hs0++;
               if (hs0_first < 0) hs0_first = i;
            end
         end
         if (i == 1640 || i == 1647) check("line0_vid_pre", 32'(d_period), 32'd1);
         if (i == 1648 || i == 1649) check("line0_vid_gb", 32'(d_period), 32'd2);
         if (i == 1650) check("line1_video", 32'(d_period), 32'd3);
         if (d_frame_start) d_fs_cnt++;
         if (d_vsync) d_vs_cnt++;

         if (i >= L10 && i < L10 + 44 && d_island_ack) ack10++;
         case (i - L10)
            0, 7:    check("isl_pre", 32'(d_period), 32'd4);
            8, 9:    check("isl_gb_lead", 32'(d_period), 32'd5);
            10: begin
               check("isl_data_first", 32'(d_period), 32'd6);
               check("isl_ack_first", 32'(d_island_ack), 32'd1);
            end
            41:      check("isl_data_last", 32'(d_period), 32'd6);
            42, 43:  check("isl_gb_trail", 32'(d_period), 32'd5);
            44:      check("isl_end_ctrl", 32'(d_period), 32'd0);
            default: ;
         endcase
         if ((i >= L11 && i < L11 + 44) || (i >= L12 && i < L12 + 44))
            if (d_period != 3'd0 || d_island_ack) quiet++;

         if (i < 1920) begin
            if (!s_vsync) begin
               s_vs++;
               if (s_vs_first < 0) s_vs_first = i;
            end
            if (s_period == 3'd1) s_pre++;
            if (s_period == 3'd2) s_gb++;
         end
         if (i == 1920) check("small_frame_period", 32'(s_frame_start), 32'd1);

         case (rst_phase)
            0: if (frames[1] >= 3 && mv[1] == 7 && mh[1] == 50) begin
               rst_s = 1'b0;
               rst_phase = 1;
            end
            1: begin
               check("midrst_period", 32'(s_period), 32'd0);
               check("midrst_ack", 32'(s_island_ack), 32'd0);
               check("midrst_video_en", 32'(s_video_en), 32'd0);
               check("midrst_hsync", 32'(s_hsync), 32'd1);
               rst_s = 1'b1;
               rst_phase = 2;
            end
            2: begin
               check("midrst_restart_fs", 32'(s_frame_start), 32'd1);
               check("midrst_restart_hcnt", 32'(s_hcnt), 32'd0);
               rst_phase = 3;
            end
            3: begin
               if (s_island_ack) ack_after++;
               ack_win++;
               if (ack_win == 40) rst_phase = 4;
            end
            default: ;
         endcase
      end

      check("line0_en_count", 32'(en0), 32'd1280);
      check("line0_hsync_count", 32'(hs0), 32'd40);
      check("line0_hsync_start", 32'(hs0_first), 32'd1390);
      check("default_no_second_frame", 32'(d_fs_cnt), 32'd0);
      check("default_no_vsync", 32'(d_vs_cnt), 32'd0);
      check("line10_ack_count", 32'(ack10), 32'd1);
      check("line11_12_quiet", 32'(quiet), 32'd0);
      check("small_vsync_count", 32'(s_vs), 32'd288);
      check("small_vsync_start", 32'(s_vs_first), 32'd1152);
      check("small_vid_pre_count", 32'(s_pre), 32'd80);
      check("small_vid_gb_count", 32'(s_gb), 32'd20);
      check("midrst_done", 32'(rst_phase), 32'd4);
      check("midrst_no_late_ack", 32'(ack_after), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
